// File: rtl/calc_op_seq.sv
// Operation sequencer for the 3-bit signed calculator: accepts add/sub/mul requests,
// drives the external sign-magnitude multiplier and hands off one 5-bit result at a time.
module calc_op_seq #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             in_ready,
    input  logic [2:0]       a_in,
    input  logic [2:0]       b_in,
    input  logic [1:0]       op_in,
    output logic [2:0]       mul_a,
    output logic [2:0]       mul_b,
    input  logic [4:0]       mul_product,
    output logic [4:0]       res,
    output logic             res_err,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    logic [1:0] state;
    logic [1:0] op_q;

    logic signed [4:0] val_a;
    logic signed [4:0] val_b;
    logic signed [4:0] arith;
    logic signed [4:0] arith_mag;
    logic              arith_neg;
    logic [4:0]        res_n;
    logic              err_n;

    // Negative zero is folded to +0 so the multiplier and adder never see it.
    function automatic logic [2:0] norm(input logic [2:0] x);
        return (x == 3'b100) ? 3'b000 : x;
    endfunction

    function automatic logic signed [4:0] sm_value(input logic [2:0] x);
        logic signed [4:0] m;
        m = $signed({3'b000, x[1:0]});
        return x[2] ? -m : m;
    endfunction

    assign in_ready = (state == IDLE);

    always_comb begin
        val_a     = sm_value(mul_a);
        val_b     = sm_value(mul_b);
        arith     = (op_q == OP_SUB) ? (val_a - val_b) : (val_a + val_b);
        arith_neg = (arith < 0);
        arith_mag = arith_neg ? -arith : arith;
        res_n     = '0;
        err_n     = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB: res_n = {arith_neg, arith_mag[3:0]};
            OP_MUL:         res_n = (mul_product[3:0] == 4'd0) ? 5'b00000 : mul_product;
            default: begin
                res_n = '0;
                err_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= OP_ADD;
            mul_a     <= '0;
            mul_b     <= '0;
            res       <= '0;
            res_err   <= 1'b0;
            res_valid <= 1'b0;
            op_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mul_a <= norm(a_in);
                        mul_b <= norm(b_in);
                        op_q  <= op_in;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    res       <= res_n;
                    res_err   <= err_n;
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + CNT_W'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
